// File: rtl/pll_reset_seq.sv
// -----------------------------------------------------------------------------
// pll_reset_seq
//
// Bring-up sequencer for the iCE40 PLL. It holds the PLL in reset for a fixed
// number of reference clocks, then waits for the PLL LOCK output to stay high
// long enough to be trusted. Only after that, and a further settling delay,
// does it release the system reset.
//
// Failure handling:
//   - If lock never settles within the timeout window, the PLL is pulsed again.
//   - After MAX_RETRIES such retries the block parks in FAILED.
//   - Losing lock after the PLL has been trusted restarts the sequence without
//     counting as a retry.
//
// The block runs on the PLL reference clock (the board oscillator). It
// therefore keeps working while the PLL output is dead.
//
// Ports:
//   clk        in   reference clock, same net as the PLL REFERENCECLK
//   rst        in   synchronous active-high reset, highest priority
//   lock_async in   PLL LOCK, asynchronous to clk
//   restart    in   single-cycle request to rerun the whole sequence
//   pll_resetb out  to PLL RESETB, 0 holds the PLL in reset
//   sys_rst    out  registered system reset, active high
//   ready      out  1 only while running with a trusted lock
//   fail       out  1 only once the retry budget is exhausted
//   retries    out  lock timeouts since the last rst/restart, saturating
// -----------------------------------------------------------------------------
module pll_reset_seq #(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 12000,
  parameter int LOCK_STABLE    = 256,
  parameter int RELEASE_DELAY  = 16,
  parameter int MAX_RETRIES    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lock_async,
  input  logic       restart,
  output logic       pll_resetb,
  output logic       sys_rst,
  output logic       ready,
  output logic       fail,
  output logic [3:0] retries
);

  // The phase counter is shared by PLL_RST, STABLE and RELEASE.
  // It is sized for the longest of the three phases.
  localparam int CNT_MAX_A = (PLL_RST_CYCLES > LOCK_STABLE) ? PLL_RST_CYCLES : LOCK_STABLE;
  localparam int CNT_MAX   = (CNT_MAX_A > RELEASE_DELAY) ? CNT_MAX_A : RELEASE_DELAY;
  localparam int CNT_W     = $clog2(CNT_MAX) + 1;
  localparam int TMO_W     = $clog2(LOCK_TIMEOUT + 1);

  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_DONE  = CNT_W'(LOCK_STABLE);
  localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'(RELEASE_DELAY - 1);
  localparam logic [TMO_W-1:0] TMO_ONE      = TMO_W'(1);
  localparam logic [TMO_W-1:0] TMO_LAST     = TMO_W'(LOCK_TIMEOUT - 1);
  localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4,
    FAILED    = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [3:0]       retries_q, retries_d;
  logic             lockMeta_q, lockSync_q;
  logic             pllResetb_q, sysRst_q, ready_q, fail_q;
  logic             lockS;
  logic             timeout;

  assign lockS   = lockSync_q;
  assign timeout = (tmo_q == TMO_LAST);

  // Next-state logic for the sequencer.
  //
  // restart overrides everything in the state machine. Within WAIT_LOCK and
  // STABLE, the timeout is checked before lock progress, so a timeout landing
  // on the same cycle as a completed stability count still forces a retry.
  //
  // The timeout fires on the LOCK_TIMEOUT-th cycle after the PLL was let out
  // of reset. tmo is deliberately left running when lock drops back out of
  // STABLE, so a glitchy lock cannot stretch the window.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    retries_d = retries_q;

    if (restart) begin
      state_d   = PLL_RST;
      cnt_d     = '0;
      tmo_d     = '0;
      retries_d = '0;
    end else begin
      case (state_q)
        PLL_RST: begin
          if (cnt_q == RST_LAST) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
            tmo_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end

        WAIT_LOCK, STABLE: begin
          if (timeout) begin
            cnt_d = '0;
            tmo_d = '0;
            if (retries_q < RETRY_LIMIT) begin
              retries_d = retries_q + 4'd1;
              state_d   = PLL_RST;
            end else begin
              state_d = FAILED;
            end
          end else begin
            tmo_d = tmo_q + TMO_ONE;
            if (state_q == WAIT_LOCK) begin
              if (lockS) begin
                state_d = STABLE;
                cnt_d   = CNT_ONE;
              end
            end else if (!lockS) begin
              state_d = WAIT_LOCK;
            end else if (cnt_q == STABLE_DONE) begin
              state_d = RELEASE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
        end

        RELEASE: begin
          if (!lockS) begin
            state_d = PLL_RST;
            cnt_d   = '0;
            tmo_d   = '0;
          end else if (cnt_q == RELEASE_LAST) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end

        RUN: begin
          if (!lockS) begin
            state_d = PLL_RST;
            cnt_d   = '0;
            tmo_d   = '0;
          end
        end

        FAILED: begin
          state_d = FAILED;
        end

        default: begin
          state_d = PLL_RST;
          cnt_d   = '0;
          tmo_d   = '0;
        end
      endcase
    end
  end

  // All state lives in this single register block.
  //
  // The lock synchronizer is the only place the raw lock_async is sampled.
  //
  // The outputs are registered copies of functions of the next state. They
  // therefore change on the same edge as the state itself, without any
  // combinational path to the pins. This is what keeps sys_rst glitch-free
  // and ready an exact complement of it.
  always_ff @(posedge clk) begin
    if (rst) begin
      lockMeta_q  <= 1'b0;
      lockSync_q  <= 1'b0;
      state_q     <= PLL_RST;
      cnt_q       <= '0;
      tmo_q       <= '0;
      retries_q   <= '0;
      pllResetb_q <= 1'b0;
      sysRst_q    <= 1'b1;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      lockMeta_q  <= lock_async;
      lockSync_q  <= lockMeta_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      retries_q   <= retries_d;
      pllResetb_q <= (state_d != PLL_RST) && (state_d != FAILED);
      sysRst_q    <= (state_d != RUN);
      ready_q     <= (state_d == RUN);
      fail_q      <= (state_d == FAILED);
    end
  end

  assign pll_resetb = pllResetb_q;
  assign sys_rst    = sysRst_q;
  assign ready      = ready_q;
  assign fail       = fail_q;
  assign retries    = retries_q;

endmodule

// File: tb/tb_pll_reset_seq.sv
// -----------------------------------------------------------------------------
// tb_pll_reset_seq
//
// Directed bench for pll_reset_seq using small parameters:
//   4-cycle PLL reset, 8-cycle lock stability, 4-cycle release delay,
//   50-cycle lock timeout, 2 retries.
//
// Expected cycle counts below are derived by hand from those parameters.
// -----------------------------------------------------------------------------
module tb_pll_reset_seq;

  localparam int P_RST  = 4;
  localparam int P_STAB = 8;
  localparam int P_REL  = 4;
  localparam int P_TMO  = 50;
  localparam int P_RETR = 2;
  localparam int LOCK_TO_RUN = 2 + P_STAB + P_REL + 1;

  localparam int SEL_RESETB = 0;
  localparam int SEL_SYSRST = 1;
  localparam int SEL_READY  = 2;

  logic       clk;
  logic       rst;
  logic       lockAsync;
  logic       restart;
  logic       pllResetb;
  logic       sysRst;
  logic       ready;
  logic       fail;
  logic [3:0] retries;

  int total;
  int bad;
  int pairViolations;
  bit monitorOn;

  pll_reset_seq #(
    .PLL_RST_CYCLES(P_RST),
    .LOCK_TIMEOUT  (P_TMO),
    .LOCK_STABLE   (P_STAB),
    .RELEASE_DELAY (P_REL),
    .MAX_RETRIES   (P_RETR)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .lock_async(lockAsync),
    .restart   (restart),
    .pll_resetb(pllResetb),
    .sys_rst   (sysRst),
    .ready     (ready),
    .fail      (fail),
    .retries   (retries)
  );

  // 10 ns reference clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ready must always be the exact complement of sys_rst once out of reset.
  always @(negedge clk) begin
    if (monitorOn && (ready !== ~sysRst)) pairViolations++;
  end

  // Hard stop in case a bounded wait itself misbehaves.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Drives lock and restart mid-cycle, away from the sampling edge.
  task automatic applyStimulus(input logic lockVal, input logic restartVal);
    @(negedge clk);
    lockAsync = lockVal;
    restart   = restartVal;
  endtask

  function automatic logic sigSel(input int which);
    case (which)
      SEL_RESETB: return pllResetb;
      SEL_SYSRST: return sysRst;
      default:    return ready;
    endcase
  endfunction

  // Counts rising edges until the selected output reads val (sampled 1 ns
  // after each edge). If the limit is exceeded, returns maxN+1.
  task automatic cyclesUntil(input int which, input logic val, input int maxN, output int n);
    n = 0;
    while (sigSel(which) !== val && n <= maxN) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_resetb"},  int'(pllResetb), 0);
    checkOutput({tag, "_sysrst"},  int'(sysRst), 1);
    checkOutput({tag, "_ready"},   int'(ready), 0);
    checkOutput({tag, "_fail"},    int'(fail), 0);
    checkOutput({tag, "_retries"}, int'(retries), 0);
  endtask

  // Pulses restart for exactly one sampling edge, with lock low.
  // Checks the outputs right after that edge.
  task automatic pulseRestart(input string tag);
    applyStimulus(1'b0, 1'b1);
    @(posedge clk);
    #1;
    checkResetValues(tag);
    applyStimulus(1'b0, 1'b0);
  endtask

  int n;
  int holdBad;

  initial begin
    total          = 0;
    bad            = 0;
    pairViolations = 0;
    monitorOn      = 1'b0;
    rst            = 1'b1;
    lockAsync      = 1'b0;
    restart        = 1'b0;

    // Reset state, including the PLL reset pulse length after release.
    repeat (3) @(posedge clk);
    #1;
    checkResetValues("rst");
    monitorOn = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cyclesUntil(SEL_RESETB, 1'b1, 20, n);
    checkOutput("nom_resetbLow", n, P_RST);
    checkOutput("nom_sysrstHeld", int'(sysRst), 1);

    // Nominal bring-up: lock rises 5 cycles after the PLL leaves reset.
    repeat (5) @(posedge clk);
    applyStimulus(1'b1, 1'b0);
    cyclesUntil(SEL_SYSRST, 1'b0, 40, n);
    checkOutput("nom_latency", n, LOCK_TO_RUN);
    checkOutput("nom_ready", int'(ready), 1);
    checkOutput("nom_retries", int'(retries), 0);
    checkOutput("nom_resetbHigh", int'(pllResetb), 1);

    // Lock loss in RUN: the reaction is seen 3 edges after lock drops.
    applyStimulus(1'b0, 1'b0);
    cyclesUntil(SEL_SYSRST, 1'b1, 10, n);
    checkOutput("loss_reaction", n, 3);
    checkOutput("loss_ready", int'(ready), 0);
    checkOutput("loss_resetbLow", int'(pllResetb), 0);
    cyclesUntil(SEL_RESETB, 1'b1, 20, n);
    checkOutput("loss_pulseLen", n, P_RST);
    applyStimulus(1'b1, 1'b0);
    cyclesUntil(SEL_SYSRST, 1'b0, 40, n);
    checkOutput("loss_relock", n, LOCK_TO_RUN);
    checkOutput("loss_retries", int'(retries), 0);

    // Glitchy lock: high 5 cycles, low 1, then high.
    // Release must count from the last rise.
    pulseRestart("glitchA_restart");
    cyclesUntil(SEL_RESETB, 1'b1, 20, n);
    checkOutput("glitchA_resetbLow", n, P_RST);
    applyStimulus(1'b1, 1'b0);
    repeat (5) @(posedge clk);
    applyStimulus(1'b0, 1'b0);
    @(posedge clk);
    applyStimulus(1'b1, 1'b0);
    checkOutput("glitchA_noEarlyRelease", int'(sysRst), 1);
    cyclesUntil(SEL_SYSRST, 1'b0, 40, n);
    checkOutput("glitchA_latency", n, LOCK_TO_RUN);

    // Glitch late in the window. Raising lock 33 cycles in, the stability
    // count would finish exactly on cycle 50, where the timeout also fires.
    // The timeout wins only because the glitch did not reset tmo.
    pulseRestart("glitchB_restart");
    cyclesUntil(SEL_RESETB, 1'b1, 20, n);
    checkOutput("glitchB_resetbLow", n, P_RST);
    repeat (33) @(posedge clk);
    applyStimulus(1'b1, 1'b0);
    repeat (5) @(posedge clk);
    applyStimulus(1'b0, 1'b0);
    @(posedge clk);
    applyStimulus(1'b1, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    checkOutput("glitchB_beforeTmo", int'(pllResetb), 1);
    @(posedge clk);
    #1;
    checkOutput("glitchB_tmoResetb", int'(pllResetb), 0);
    checkOutput("glitchB_tmoRetries", int'(retries), 1);
    checkOutput("glitchB_tmoSysrst", int'(sysRst), 1);

    // Lock is already stable at retry, so RELEASE begins 9 edges after
    // RESETB rises. Apply rst while in RELEASE.
    cyclesUntil(SEL_RESETB, 1'b1, 20, n);
    checkOutput("retry_pulseLen", n, P_RST);
    repeat (10) @(posedge clk);
    #1;
    checkOutput("rel_sysrstHeld", int'(sysRst), 1);
    checkOutput("rel_resetbHigh", int'(pllResetb), 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkResetValues("relRst");
    @(negedge clk);
    rst = 1'b0;
    cyclesUntil(SEL_RESETB, 1'b1, 20, n);
    checkOutput("relRst_resetbLow", n, P_RST);
    cyclesUntil(SEL_READY, 1'b1, 60, n);
    checkOutput("relRst_rerunReady", int'(ready), 1);
    checkOutput("relRst_rerunRetries", int'(retries), 0);

    // Timeout/retry with lock never asserted.
    pulseRestart("tmo_restart");
    cyclesUntil(SEL_RESETB, 1'b1, 20, n);
    for (int r = 1; r <= P_RETR; r++) begin
      cyclesUntil(SEL_RESETB, 1'b0, 100, n);
      checkOutput($sformatf("tmo%0d_window", r), n, P_TMO);
      checkOutput($sformatf("tmo%0d_retries", r), int'(retries), r);
      checkOutput($sformatf("tmo%0d_fail", r), int'(fail), 0);
      cyclesUntil(SEL_RESETB, 1'b1, 20, n);
      checkOutput($sformatf("tmo%0d_pulseLen", r), n, P_RST);
    end
    cyclesUntil(SEL_RESETB, 1'b0, 100, n);
    checkOutput("tmoF_window", n, P_TMO);
    checkOutput("tmoF_fail", int'(fail), 1);
    checkOutput("tmoF_sysrst", int'(sysRst), 1);
    checkOutput("tmoF_retries", int'(retries), P_RETR);
    holdBad = 0;
    repeat (100) begin
      @(posedge clk);
      #1;
      if (!(fail === 1'b1 && pllResetb === 1'b0 && sysRst === 1'b1 && ready === 1'b0))
        holdBad++;
    end
    checkOutput("tmoF_hold100", holdBad, 0);

    // restart out of FAILED, then a normal bring-up.
    pulseRestart("failRestart");
    cyclesUntil(SEL_RESETB, 1'b1, 20, n);
    checkOutput("failRestart_pulseLen", n, P_RST);
    applyStimulus(1'b1, 1'b0);
    cyclesUntil(SEL_SYSRST, 1'b0, 40, n);
    checkOutput("failRestart_latency", n, LOCK_TO_RUN);
    checkOutput("failRestart_ready", int'(ready), 1);

    // restart on the same edge as the final timeout. Without restart
    // priority, this edge would enter FAILED.
    pulseRestart("coinc_restart");
    cyclesUntil(SEL_RESETB, 1'b1, 20, n);
    for (int r = 1; r <= P_RETR; r++) begin
      cyclesUntil(SEL_RESETB, 1'b0, 100, n);
      checkOutput($sformatf("coinc%0d_window", r), n, P_TMO);
      cyclesUntil(SEL_RESETB, 1'b1, 20, n);
    end
    checkOutput("coinc_retriesBefore", int'(retries), P_RETR);
    repeat (P_TMO - 1) @(posedge clk);
    #1;
    checkOutput("coinc_beforeTmo", int'(pllResetb), 1);
    pulseRestart("coinc");
    cyclesUntil(SEL_RESETB, 1'b1, 20, n);
    checkOutput("coinc_pulseLen", n, P_RST);
    applyStimulus(1'b1, 1'b0);
    cyclesUntil(SEL_SYSRST, 1'b0, 40, n);
    checkOutput("coinc_latency", n, LOCK_TO_RUN);
    checkOutput("coinc_retriesAfter", int'(retries), 0);
    checkOutput("coinc_fail", int'(fail), 0);

    checkOutput("readyIsNotSysRst", pairViolations, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
